// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbitrated shared register with lockable ownership (optional q_par via SHARED_REG_PARITY_EN)
module shared_reg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         lock,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   q,
  output logic [1:0]         q_owner,
  output logic               q_upd
`ifdef SHARED_REG_PARITY_EN
  ,
  output logic               q_par
`endif
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, win, idx, wsel;
  logic hit, wr;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] gnt_q, gnt_d;
  logic upd_q;
  // round-robin pick: lowest offset from ptr with req set
  always_comb begin
    win = ptr_q;
    hit = 1'b0;
    idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  // ownership FSM; in OWNED owner_q doubles as the lock holder
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    wr = 1'b0;
    wsel = win;
    if (state_q == IDLE) begin
      if (hit) begin
        wr = 1'b1;
        ptr_d = win + 2'd1;
        state_d = lock[win] ? OWNED : IDLE;
      end
    end else if (req[owner_q]) begin
      wr = 1'b1;
      wsel = owner_q;
    end else begin
      state_d = IDLE;
      ptr_d = owner_q + 2'd1;
    end
  end
  // datapath next-state for the accepted write
  always_comb begin
    data_d = wr ? din[wsel*WIDTH +: WIDTH] : data_q;
    owner_d = wr ? wsel : owner_q;
    gnt_d = wr ? 4'b0001 << wsel : 4'b0000;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      data_q <= '0;
      owner_q <= '0;
      gnt_q <= '0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      data_q <= data_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      upd_q <= wr;
    end
  end
`ifdef SHARED_REG_PARITY_EN
  logic par_q;
  // parity tracks q, updated in the same edge
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= ^data_d;
  end
  assign q_par = par_q;
`endif
  assign gnt = gnt_q;
  assign q = data_q;
  assign q_owner = owner_q;
  assign q_upd = upd_q;
endmodule
